// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter: shares one synchronous FIFO write port among NUM_REQ
// valid/ready requesters. Each grant is held for up to BURST_LEN beats.
module fifo_wr_arbiter #(
    parameter int unsigned DT_WIDTH  = 8,
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned BURST_LEN = 4,
    parameter int unsigned ID_WIDTH  = $clog2(NUM_REQ)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ*DT_WIDTH-1:0]  req_data,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic                         f_full,
    output logic                         wrt_en,
    output logic [DT_WIDTH-1:0]          wrt_dt,
    output logic                         grant_valid,
    output logic [ID_WIDTH-1:0]          grant_id
);

    localparam int unsigned CNT_W = $clog2(BURST_LEN + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [ID_WIDTH-1:0] grant_id_q, grant_id_d;
    logic [CNT_W-1:0]    beat_cnt_q, beat_cnt_d;
    logic [ID_WIDTH-1:0] pick_id;
    logic [DT_WIDTH-1:0] data_arr [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign data_arr[i] = req_data[i*DT_WIDTH +: DT_WIDTH];
    end

    // First valid requester searching from the one after the last grant
    always_comb begin
        logic                found;
        logic [ID_WIDTH-1:0] cand;
        int unsigned         idx;
        found   = 1'b0;
        pick_id = grant_id_q;
        cand    = '0;
        idx     = 0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            idx  = (32'(grant_id_q) + k) % NUM_REQ;
            cand = ID_WIDTH'(idx);
            if (!found && req_valid[cand]) begin
                found   = 1'b1;
                pick_id = cand;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            grant_id_q <= ID_WIDTH'(NUM_REQ - 1);
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            grant_id_q <= grant_id_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    // Next state; write-port signals are combinational so a beat lands in its own cycle
    always_comb begin
        state_d    = state_q;
        grant_id_d = grant_id_q;
        beat_cnt_d = beat_cnt_q;
        req_ready  = '0;
        wrt_en     = 1'b0;
        wrt_dt     = '0;
        case (state_q)
            IDLE: begin
                if (|req_valid) begin
                    grant_id_d = pick_id;
                    beat_cnt_d = '0;
                    state_d    = GRANT;
                end
            end
            GRANT: begin
                req_ready[grant_id_q] = !f_full;
                wrt_en                = req_valid[grant_id_q] & !f_full;
                wrt_dt                = data_arr[grant_id_q];
                if (!req_valid[grant_id_q]) begin
                    state_d    = IDLE;
                    beat_cnt_d = '0;
                end else if (wrt_en) begin
                    if (beat_cnt_q == CNT_W'(BURST_LEN - 1)) begin
                        state_d    = IDLE;
                        beat_cnt_d = '0;
                    end else begin
                        beat_cnt_d = beat_cnt_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign grant_valid = (state_q == GRANT);
    assign grant_id    = grant_id_q;

endmodule
